// File: rtl/exec_stage.sv
// rtl/exec_stage.sv - execute stage: single-cycle ALU ops, iterative SRA, held result packet for write-back
module exec_stage #(
  parameter int DATA_W = 14,
  parameter int ADDR_W = 12
) (
  input  logic                     clk,
  input  logic                     reset,
  input  logic                     in_valid,
  output logic                     in_ready,
  input  logic [3:0]               in_opcode,
  input  logic [DATA_W-1:0]        in_a,
  input  logic [DATA_W-1:0]        in_b,
  input  logic [ADDR_W-1:0]        in_addr,
  output logic [DATA_W+ADDR_W+3:0] DAO,
  output logic                     pause_WRITE,
  input  logic                     data_read
);

  localparam logic [3:0] OP_MOV_SR   = 4'd0;
  localparam logic [3:0] OP_MOV_BIO  = 4'd1;
  localparam logic [3:0] OP_MOV_SA   = 4'd2;
  localparam logic [3:0] OP_POP_R    = 4'd3;
  localparam logic [3:0] OP_INC_BIO  = 4'd4;
  localparam logic [3:0] OP_INC_SR   = 4'd5;
  localparam logic [3:0] OP_XOR_SR   = 4'd6;
  localparam logic [3:0] OP_XOR_BIO  = 4'd7;
  localparam logic [3:0] OP_NAND_SR  = 4'd8;
  localparam logic [3:0] OP_NAND_BIO = 4'd9;
  localparam logic [3:0] OP_SRA_SR   = 4'd10;
  localparam logic [3:0] OP_SRA_BIO  = 4'd11;

  // Shifting further than DATA_W-1 only repeats the sign bit, so cap the count there.
  localparam logic [3:0] MAX_CNT = 4'(DATA_W - 1);

  typedef enum logic [1:0] {IDLE, EXEC, OUT} state_t;

  state_t                    state, state_d;
  logic [3:0]                op_q, op_d;
  logic [DATA_W-1:0]         a_q, a_d;
  logic [DATA_W-1:0]         b_q, b_d;
  logic [ADDR_W-1:0]         addr_q, addr_d;
  logic [3:0]                cnt_q, cnt_d;
  logic                      in_ready_d;
  logic                      pause_d;
  logic [DATA_W+ADDR_W+3:0]  dao_d;
  logic [DATA_W-1:0]         result;
  logic                      known;
  logic                      is_sra;

  always_comb begin
    result = '0;
    known  = 1'b1;
    is_sra = 1'b0;
    case (op_q)
      OP_MOV_SR, OP_MOV_BIO, OP_MOV_SA, OP_POP_R: result = a_q;
      OP_INC_BIO, OP_INC_SR:                      result = a_q + 1'b1;
      OP_XOR_SR, OP_XOR_BIO:                      result = a_q ^ b_q;
      OP_NAND_SR, OP_NAND_BIO:                    result = ~(a_q & b_q);
      OP_SRA_SR, OP_SRA_BIO: begin
        result = a_q;
        is_sra = 1'b1;
      end
      default: known = 1'b0;
    endcase
  end

  always_comb begin
    state_d    = state;
    op_d       = op_q;
    a_d        = a_q;
    b_d        = b_q;
    addr_d     = addr_q;
    cnt_d      = cnt_q;
    in_ready_d = in_ready;
    pause_d    = pause_WRITE;
    dao_d      = DAO;
    case (state)
      IDLE: begin
        in_ready_d = 1'b1;
        // Accept only once in_ready is visible upstream (not on the first edge after reset).
        if (in_valid && in_ready) begin
          op_d       = in_opcode;
          a_d        = in_a;
          b_d        = in_b;
          addr_d     = in_addr;
          cnt_d      = (in_b[3:0] > MAX_CNT) ? MAX_CNT : in_b[3:0];
          in_ready_d = 1'b0;
          state_d    = EXEC;
        end
      end
      EXEC: begin
        if (!known) begin
          in_ready_d = 1'b1;
          state_d    = IDLE;
        end else if (is_sra && (cnt_q != 4'd0)) begin
          a_d   = {a_q[DATA_W-1], a_q[DATA_W-1:1]};
          cnt_d = cnt_q - 4'd1;
        end else begin
          dao_d   = {result, addr_q, op_q};
          pause_d = 1'b0;
          state_d = OUT;
        end
      end
      OUT: begin
        if (data_read) begin
          pause_d    = 1'b1;
          in_ready_d = 1'b1;
          state_d    = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state       <= IDLE;
      op_q        <= '0;
      a_q         <= '0;
      b_q         <= '0;
      addr_q      <= '0;
      cnt_q       <= '0;
      in_ready    <= 1'b0;
      pause_WRITE <= 1'b1;
      DAO         <= '0;
    end else begin
      state       <= state_d;
      op_q        <= op_d;
      a_q         <= a_d;
      b_q         <= b_d;
      addr_q      <= addr_d;
      cnt_q       <= cnt_d;
      in_ready    <= in_ready_d;
      pause_WRITE <= pause_d;
      DAO         <= dao_d;
    end
  end

endmodule

// File: tb/tb_exec_stage.sv
// tb/tb_exec_stage.sv - self-checking bench for exec_stage: vector table, corner sequences, random vs model
module tb_exec_stage;

  localparam int DATA_W = 14;
  localparam int ADDR_W = 12;

  localparam logic [3:0] OP_MOV_SR   = 4'd0;
  localparam logic [3:0] OP_INC_SR   = 4'd5;
  localparam logic [3:0] OP_XOR_SR   = 4'd6;
  localparam logic [3:0] OP_NAND_BIO = 4'd9;
  localparam logic [3:0] OP_SRA_SR   = 4'd10;
  localparam logic [3:0] OP_SRA_BIO  = 4'd11;

  logic                     clk = 1'b0;
  logic                     reset;
  logic                     in_valid;
  logic                     in_ready;
  logic [3:0]               in_opcode;
  logic [DATA_W-1:0]        in_a;
  logic [DATA_W-1:0]        in_b;
  logic [ADDR_W-1:0]        in_addr;
  logic [DATA_W+ADDR_W+3:0] DAO;
  logic                     pause_WRITE;
  logic                     data_read;

  int tests  = 0;
  int failed = 0;

  exec_stage #(.DATA_W(DATA_W), .ADDR_W(ADDR_W)) dut (
    .clk(clk), .reset(reset), .in_valid(in_valid), .in_ready(in_ready),
    .in_opcode(in_opcode), .in_a(in_a), .in_b(in_b), .in_addr(in_addr),
    .DAO(DAO), .pause_WRITE(pause_WRITE), .data_read(data_read)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [3:0]        op;
    logic [DATA_W-1:0] a;
    logic [DATA_W-1:0] b;
    logic [ADDR_W-1:0] addr;
    logic [DATA_W-1:0] res;
    int                lat;
  } vec_t;

  vec_t vecs[8];

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      failed++;
      $display("FAIL %s: got %h, expected %h", name, act, exp);
    end
  endtask

  // Reference: results from plain arithmetic, latency = cycles from accept edge to packet.
  function automatic logic [DATA_W-1:0] model_res(input logic [3:0] op, input logic [DATA_W-1:0] a,
                                                  input logic [DATA_W-1:0] b);
    int s;
    s = (int'(b[3:0]) > DATA_W - 1) ? DATA_W - 1 : int'(b[3:0]);
    if (op <= 4'd3) return a;
    if (op == 4'd4 || op == 4'd5) return DATA_W'((int'(a) + 1) % (1 << DATA_W));
    if (op == 4'd6 || op == 4'd7) return a ^ b;
    if (op == 4'd8 || op == 4'd9) return ~(a & b);
    if (op == 4'd10 || op == 4'd11) return DATA_W'($signed(a) >>> s);
    return '0;
  endfunction

  function automatic int model_lat(input logic [3:0] op, input logic [DATA_W-1:0] b);
    int s;
    s = (int'(b[3:0]) > DATA_W - 1) ? DATA_W - 1 : int'(b[3:0]);
    if (op <= 4'd9) return 1;
    if (op <= 4'd11) return 1 + s;
    return 0;
  endfunction

  task automatic issue(input string name, input logic [3:0] op, input logic [DATA_W-1:0] a,
                       input logic [DATA_W-1:0] b, input logic [ADDR_W-1:0] addr,
                       input logic [DATA_W-1:0] res, input int lat);
    int n;
    logic [DATA_W+ADDR_W+3:0] pkt;
    n = 0;
    while (!in_ready && n < 20) begin
      tick();
      n++;
    end
    check({name, " ready"}, 32'(in_ready), 32'd1);
    in_valid = 1'b1; in_opcode = op; in_a = a; in_b = b; in_addr = addr;
    tick();
    in_valid = 1'b0;
    check({name, " busy"}, {30'd0, in_ready, pause_WRITE}, 32'd1);
    if (lat == 0) begin
      tick();
      check({name, " discard"}, {30'd0, in_ready, pause_WRITE}, 32'd3);
      return;
    end
    n = 1;
    tick();
    while (pause_WRITE && n < 40) begin
      tick();
      n++;
    end
    check({name, " latency"}, 32'(n), 32'(lat));
    pkt = {res, addr, op};
    check({name, " DAO"}, 32'(DAO), 32'(pkt));
    tick();
    check({name, " hold"}, 32'(DAO), 32'(pkt));
    data_read = 1'b1;
    tick();
    data_read = 1'b0;
    check({name, " consume"}, {30'd0, in_ready, pause_WRITE}, 32'd3);
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [DATA_W+ADDR_W+3:0] held;
    int bad;
    vecs[0] = '{OP_XOR_SR,   14'h1234, 14'h0F0F, 12'h055, 14'h1D3B, 1};
    vecs[1] = '{OP_INC_SR,   14'h3FFF, 14'h0000, 12'h001, 14'h0000, 1};
    vecs[2] = '{OP_NAND_BIO, 14'h3FFF, 14'h00FF, 12'hABC, 14'h3F00, 1};
    vecs[3] = '{OP_SRA_BIO,  14'h2000, 14'h0003, 12'h123, 14'h3C00, 4};
    vecs[4] = '{OP_SRA_BIO,  14'h2000, 14'h000F, 12'h456, 14'h3FFF, 14};
    vecs[5] = '{OP_SRA_SR,   14'h1F00, 14'h0000, 12'h789, 14'h1F00, 1};
    vecs[6] = '{OP_MOV_SR,   14'h0ABC, 14'h1111, 12'hFFF, 14'h0ABC, 1};
    vecs[7] = '{4'd13,       14'h0001, 14'h0002, 12'h003, 14'h0000, 0};

    reset = 1'b1; in_valid = 1'b0; in_opcode = '0; in_a = '0; in_b = '0; in_addr = '0;
    data_read = 1'b0;
    for (int i = 0; i < 3; i++) begin
      tick();
      check($sformatf("reset cyc%0d", i), {1'b0, in_ready, pause_WRITE, 29'(DAO)}, {1'b0, 1'b0, 1'b1, 29'd0});
    end
    reset = 1'b0;
    tick();
    check("ready after reset", 32'(in_ready), 32'd1);

    data_read = 1'b1;
    tick(); tick();
    data_read = 1'b0;
    check("stray data_read", {30'd0, in_ready, pause_WRITE}, 32'd3);

    for (int i = 0; i < 8; i++)
      issue($sformatf("vec%0d", i), vecs[i].op, vecs[i].a, vecs[i].b, vecs[i].addr, vecs[i].res, vecs[i].lat);

    // Back-pressure: packet must hold while a new instruction waits upstream.
    in_valid = 1'b1; in_opcode = OP_XOR_SR; in_a = 14'h0F0F; in_b = 14'h00F0; in_addr = 12'h321;
    tick(); tick();
    check("bp present", 32'(pause_WRITE), 32'd0);
    held = DAO;
    check("bp DAO", 32'(held), 32'({14'h0FFF, 12'h321, OP_XOR_SR}));
    in_opcode = OP_MOV_SR; in_a = 14'h0155; in_b = 14'h0000; in_addr = 12'h0AA;
    bad = 0;
    for (int i = 0; i < 10; i++) begin
      tick();
      if (DAO !== held || in_ready !== 1'b0 || pause_WRITE !== 1'b0) bad++;
    end
    check("bp stall", 32'(bad), 32'd0);
    data_read = 1'b1;
    tick();
    data_read = 1'b0;
    check("bp consume", {30'd0, in_ready, pause_WRITE}, 32'd3);
    tick();
    in_valid = 1'b0;
    check("bp accept", {30'd0, in_ready, pause_WRITE}, 32'd1);
    tick();
    check("bp next DAO", {1'b0, pause_WRITE, 30'(DAO)}, {2'b00, 14'h0155, 12'h0AA, OP_MOV_SR});
    data_read = 1'b1;
    tick();
    data_read = 1'b0;

    // Reset during an SRA shift drops the instruction.
    in_valid = 1'b1; in_opcode = OP_SRA_SR; in_a = 14'h2AAA; in_b = 14'h0005; in_addr = 12'h111;
    tick();
    in_valid = 1'b0;
    tick(); tick();
    reset = 1'b1;
    tick();
    check("rst mid-sra", {1'b0, in_ready, pause_WRITE, 29'(DAO)}, {1'b0, 1'b0, 1'b1, 29'd0});
    reset = 1'b0;
    bad = 0;
    for (int i = 0; i < 8; i++) begin
      tick();
      if (pause_WRITE !== 1'b1) bad++;
    end
    check("no pkt after rst", 32'(bad), 32'd0);

    // Reset while a packet waits in OUT.
    in_valid = 1'b1; in_opcode = OP_INC_SR; in_a = 14'h0010; in_b = '0; in_addr = 12'h222;
    tick();
    in_valid = 1'b0;
    tick();
    check("out before rst", 32'(pause_WRITE), 32'd0);
    reset = 1'b1;
    tick();
    check("rst in out", {1'b0, in_ready, pause_WRITE, 29'(DAO)}, {1'b0, 1'b0, 1'b1, 29'd0});
    reset = 1'b0;
    tick();
    check("ready after rst2", {30'd0, in_ready, pause_WRITE}, 32'd3);

    for (int i = 0; i < 40; i++) begin
      logic [3:0]        op;
      logic [DATA_W-1:0] a, b;
      logic [ADDR_W-1:0] ad;
      op = 4'($urandom_range(0, 15));
      a  = DATA_W'($urandom);
      b  = DATA_W'($urandom);
      ad = ADDR_W'($urandom);
      issue($sformatf("rand%0d op%0d", i, op), op, a, b, ad, model_res(op, a, b), model_lat(op, b));
    end

    $display("[TB] %0d tests run, %0d failed", tests, failed);
    $finish;
  end

endmodule

// File: doc/exec_stage.md
# exec_stage

Execute stage of the CPU pipeline, directly upstream of the write-back stage. It accepts one decoded instruction at a time (opcode, two operands, destination address) and computes the result: single-cycle for MOV/INC/XOR/NAND/POP, iterative one-bit-per-cycle arithmetic shift for SRA. It presents the result to write-back as the packed `DAO` word and holds it until write-back signals consumption on `data_read`.

## Interface
- `DATA_W`, 14, operand/result width
- `ADDR_W`, 12, destination address width
- `clk`  in  1  clock
- `reset`  in  1  reset, synchronous, active-high
- `in_valid`  in  1  upstream instruction valid
- `in_ready`  out  1  stage can accept an instruction (registered)
- `in_opcode`  in  4  opcode; encodings per `opcodes.v`
- `in_a`  in  DATA_W  operand A
- `in_b`  in  DATA_W  operand B; SRA uses `in_b[3:0]` as shift count
- `in_addr`  in  ADDR_W  destination address (RAM or GPR, per opcode)
- `DAO`  out  DATA_W+ADDR_W+4  packet `{result, addr, opcode}`: result in `[DATA_W+ADDR_W+3:ADDR_W+4]`, addr in `[ADDR_W+3:4]`, opcode in `[3:0]`
- `pause_WRITE`  out  1  0 = `DAO` holds a valid unconsumed packet; 1 = nothing to read
- `data_read`  in  1  write-back consume pulse

## Operation
- Reset values: `in_ready`=0, `pause_WRITE`=1, `DAO`=0, state IDLE, internal operand/count registers 0.
- FSM states: IDLE, EXEC, OUT.
- **IDLE**: `in_ready`=1. On an edge with `in_valid`=1, latch the opcode, A, B, addr and shift count `min(in_b[3:0], DATA_W-1)`, set `in_ready`<=0, and go to EXEC. Otherwise stay in IDLE.
- **EXEC**, result by opcode (all results are DATA_W bits, truncated):
  - `OP_MOV_SR`, `OP_MOV_BIO`, `OP_MOV_SA`, `OP_POP_R`: A
  - `OP_INC_BIO`, `OP_INC_SR`: A+1 mod 2^DATA_W (0x3FFF -> 0x0000)
  - `OP_XOR_SR`, `OP_XOR_BIO`: A ^ B
  - `OP_NAND_SR`, `OP_NAND_BIO`: ~(A & B)
  - `OP_SRA_SR`, `OP_SRA_BIO`: while count != 0, shift A right one bit with MSB replicated and decrement count, one step per cycle. When count == 0, A is the result.
  - Any other opcode: discarded. No packet is produced; return to IDLE and set `in_ready`<=1.
- EXEC completion (non-SRA, or SRA with count==0): load `DAO` <= `{result, addr, opcode}`, set `pause_WRITE`<=0, go to OUT.
- **OUT**: `DAO` and `pause_WRITE`=0 are held stable. On an edge with `data_read`=1, the packet is consumed: `pause_WRITE`<=1, `in_ready`<=1, go to IDLE. `DAO` keeps its last value; it is don't-care while `pause_WRITE`=1.
- `data_read` is ignored outside OUT, including when it is X or 1 while `pause_WRITE`=1.
- Exactly one packet is in flight; no new instruction is accepted until the current one is consumed.
- Reset at any point (mid-shift, or in OUT with an unconsumed packet) drops the in-flight instruction and restores reset values on the next edge.

## Timing
- Accept at edge k.
  - Non-SRA: `DAO` valid and `pause_WRITE`=0 after edge k+1.
  - SRA with effective count s: valid after edge k+1+s (s=0 gives the same timing as non-SRA).
- Write-back handshake: write-back samples `pause_WRITE`=0, then raises `data_read` one cycle later for exactly one cycle, and samples `DAO` on that same edge. `DAO` must therefore remain valid through the edge where `data_read`=1 is seen.
- Consume at edge c: `pause_WRITE`=1 and `in_ready`=1 after edge c. The earliest next accept is edge c+1.
- Minimum issue interval, non-SRA with immediate consume: 4 cycles (accept, exec, present, consume).
- An unknown opcode occupies the stage for 2 cycles and never drives `pause_WRITE` low.

## Test plan
- Reset held 3 cycles, then released → `pause_WRITE`=1 and `DAO`=0 throughout reset; `in_ready`=1 one edge after release.
- `OP_XOR_SR`, A=0x1234, B=0x0F0F, addr=0x055 → after edge k+1, `DAO` = {0x1D3B, 0x055, `OP_XOR_SR`} and `pause_WRITE`=0. A `data_read` pulse two cycles later gives `pause_WRITE`=1 and `in_ready`=1 on the next edge.
- `OP_INC_SR`, A=0x3FFF → result 0x0000 (wrap). Separately, `OP_NAND_BIO`, A=0x3FFF, B=0x00FF → result 0x3F00.
- `OP_SRA_BIO`, A=0x2000, B=0x0003 → `pause_WRITE` low after edge k+4, result 0x3C00. Separately, B=0x000F → count capped at 13, result 0x3FFF, valid after edge k+14.
- Back-pressure: hold `data_read`=0 for 10 cycles in OUT, with `in_valid`=1 and new operands driven → `DAO` stays unchanged and `in_ready` stays 0. After a `data_read` pulse, the new instruction is accepted at the following edge.
- Reset asserted mid-SRA (count=5), and separately reset asserted in OUT → no packet is emitted, and all outputs return to reset values on the next edge. Also: an unknown opcode → `pause_WRITE` stays 1 and `in_ready` returns to 1 after 2 cycles.
